systolic_feeder: RTL and testbench

Input staging and skew generator for the N×N floating-point systolic matrix multiplier. It buffers matrix A (row-major) and matrix B (column-major) as IEEE-754 single-precision words loaded one element per beat. On `start` it drives the array's west edge (one lane per row) and north edge (one lane per column) with diagonally skewed streams, so that each processing element sees A[i][k] and B[k][j] in the same cycle. It then pulses `done` in the first cycle in which every accumulator in the array holds its final value.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/skew_select.sv | 28 ++
 rtl/systolic_feeder.sv | 128 ++++++++++++
 tb/tb_systolic_feeder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder.
// Element width is fixed to IEEE-754 single precision; N_DEFAULT is the default array size.
package systolic_pkg;

  localparam int DW        = 32;
  localparam int N_DEFAULT = 4;

  localparam logic [DW-1:0] FP_ZERO = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

endpackage

// File: rtl/skew_select.sv
// Picks one lane's operand for the current stream step: word k is presented when t == k + LANE.
// Used for both west (row) and north (column) lanes.
module skew_select
  import systolic_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int LANE = 0,
  parameter int TW   = 4,
  parameter int DW   = systolic_pkg::DW
) (
  input  logic            en_i,
  input  logic [TW-1:0]   t_i,
  input  logic [N*DW-1:0] words_i,
  output logic [DW-1:0]   word_o
);

  always_comb begin
    word_o = DW'(FP_ZERO);
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t_i) == k + LANE) begin
          word_o = words_i[k*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers A (row-major) and B (column-major) and streams them diagonally skewed into an NxN
// systolic array, pulsing done once every accumulator holds its final value.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = systolic_pkg::DW,
  parameter int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            ld_sel,
  input  logic [AW-1:0]   ld_row,
  input  logic [AW-1:0]   ld_col,
  input  logic [DW-1:0]   ld_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [N*DW-1:0] west_o,
  output logic [N*DW-1:0] north_o
);

  localparam int TW = $clog2(3*N-2);
  localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

  state_e        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [DW-1:0] a_q [N][N];
  logic [DW-1:0] a_d [N][N];
  logic [DW-1:0] b_q [N][N];
  logic [DW-1:0] b_d [N][N];
  logic          ld_fire;
  logic          streaming;

  assign ld_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign streaming = (state_q == STREAM);

  // Out-of-range indices only exist when N is not a power of two; such beats are dropped.
  assign ld_fire = ld_valid && ld_ready && (int'(ld_row) < N) && (int'(ld_col) < N);

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (ld_fire) begin
      if (ld_sel) begin
        b_d[ld_row][ld_col] = ld_data;
      end else begin
        a_d[ld_row][ld_col] = ld_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          t_d     = '0;
        end
      end
      STREAM: begin
        if (t_q == T_LAST) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // West lane i walks along row i of A; north lane j walks down column j of B.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [N*DW-1:0] a_row;
    logic [N*DW-1:0] b_col;

    for (genvar gk = 0; gk < N; gk++) begin : g_word
      assign a_row[gk*DW +: DW] = a_q[gi][gk];
      assign b_col[gk*DW +: DW] = b_q[gk][gi];
    end

    skew_select #(.N(N), .LANE(gi), .TW(TW), .DW(DW)) u_west (
      .en_i    (streaming),
      .t_i     (t_q),
      .words_i (a_row),
      .word_o  (west_o[gi*DW +: DW])
    );

    skew_select #(.N(N), .LANE(gi), .TW(TW), .DW(DW)) u_north (
      .en_i    (streaming),
      .t_i     (t_q),
      .words_i (b_col),
      .word_o  (north_o[gi*DW +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder with N=3, so an out-of-range row index exists.
// Expected lanes come from the bench's own copy of the loaded matrices and the skew rule.
module tb_systolic_feeder;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int RUN_CYCLES = 3*N - 2;

  logic            clk;
  logic            reset;
  logic            ld_valid;
  logic            ld_ready;
  logic            ld_sel;
  logic [AW-1:0]   ld_row;
  logic [AW-1:0]   ld_col;
  logic [DW-1:0]   ld_data;
  logic            start;
  logic            busy;
  logic            done;
  logic [N*DW-1:0] west_o;
  logic [N*DW-1:0] north_o;

  logic [DW-1:0] a_m [N][N];
  logic [DW-1:0] b_m [N][N];

  int checks;
  int errors;

  systolic_feeder #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_sel   (ld_sel),
    .ld_row   (ld_row),
    .ld_col   (ld_col),
    .ld_data  (ld_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .west_o   (west_o),
    .north_o  (north_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Skew rule: west lane i carries A[i][t-i], north lane j carries B[t-j][j], zero outside the window.
  function automatic logic [N*DW-1:0] expWest(input int t);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < N) r[i*DW +: DW] = a_m[i][t-i];
    end
    return r;
  endfunction

  function automatic logic [N*DW-1:0] expNorth(input int t);
    logic [N*DW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      if (t - j >= 0 && t - j < N) r[j*DW +: DW] = b_m[t-j][j];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one cycle of load/start inputs, lets the edge consume them, then idles the inputs.
  task automatic applyStimulus(input logic v, input logic sel, input logic [AW-1:0] row,
                               input logic [AW-1:0] col, input logic [DW-1:0] data, input logic st);
    ld_valid = v;
    ld_sel   = sel;
    ld_row   = row;
    ld_col   = col;
    ld_data  = data;
    start    = st;
    stepCycle();
    ld_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Called right after the start edge; checks every stream cycle, then the done pulse and return to idle.
  // At cycle pokeAt a second start and a load beat with DEADBEEF are driven; both must be ignored.
  task automatic streamAndCheck(input string name, input int pokeAt);
    for (int c = 0; c < RUN_CYCLES; c++) begin
      checkOutput($sformatf("%s west t=%0d", name, c), west_o, expWest(c));
      checkOutput($sformatf("%s north t=%0d", name, c), north_o, expNorth(c));
      checkOutput($sformatf("%s busy t=%0d", name, c), N*DW'(busy), N*DW'(1));
      checkOutput($sformatf("%s done t=%0d", name, c), N*DW'(done), N*DW'(0));
      checkOutput($sformatf("%s ld_ready t=%0d", name, c), N*DW'(ld_ready), N*DW'(0));
      if (c == pokeAt) begin
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = 2'd1;
        ld_col   = 2'd1;
        ld_data  = 32'hDEADBEEF;
      end
      stepCycle();
      start    = 1'b0;
      ld_valid = 1'b0;
    end
    checkOutput({name, " done pulse"}, N*DW'(done), N*DW'(1));
    checkOutput({name, " busy in DONE"}, N*DW'(busy), N*DW'(1));
    checkOutput({name, " lanes zero in DONE"}, west_o | north_o, '0);
    stepCycle();
    checkOutput({name, " done cleared"}, N*DW'(done), N*DW'(0));
    checkOutput({name, " busy cleared"}, N*DW'(busy), N*DW'(0));
    checkOutput({name, " ld_ready back"}, N*DW'(ld_ready), N*DW'(1));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    ld_valid = 1'b0;
    ld_sel   = 1'b0;
    ld_row   = '0;
    ld_col   = '0;
    ld_data  = '0;
    start    = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = '0;
        b_m[r][c] = '0;
      end
    end

    stepCycle();
    stepCycle();
    checkOutput("reset ld_ready", N*DW'(ld_ready), N*DW'(1));
    checkOutput("reset busy", N*DW'(busy), N*DW'(0));
    checkOutput("reset done", N*DW'(done), N*DW'(0));
    checkOutput("reset west", west_o, '0);
    checkOutput("reset north", north_o, '0);
    reset = 1'b1;
    stepCycle();

    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = 32'hA0000000 | (r << 4) | c;
        applyStimulus(1'b1, 1'b0, AW'(r), AW'(c), a_m[r][c], 1'b0);
        b_m[r][c] = 32'hB0000000 | (r << 4) | c;
        applyStimulus(1'b1, 1'b1, AW'(r), AW'(c), b_m[r][c], 1'b0);
      end
    end

    applyStimulus(1'b1, 1'b0, 2'd3, 2'd0, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 2'd3, 32'hDEADBEEF, 1'b0);
    checkOutput("idle lanes after loads", west_o | north_o, '0);

    a_m[0][0] = 32'h40A00000;
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 32'h40A00000, 1'b1);
    streamAndCheck("run1", 2);

    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
    streamAndCheck("run2", -1);

    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("pre-abort west t=3", west_o, expWest(3));
    reset = 1'b0;
    #1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = '0;
        b_m[r][c] = '0;
      end
    end
    checkOutput("abort lanes", west_o | north_o, '0);
    checkOutput("abort busy", N*DW'(busy), N*DW'(0));
    checkOutput("abort ld_ready", N*DW'(ld_ready), N*DW'(1));
    checkOutput("abort done", N*DW'(done), N*DW'(0));
    stepCycle();
    reset = 1'b1;
    for (int c = 0; c < RUN_CYCLES + 2; c++) begin
      stepCycle();
      checkOutput($sformatf("no done after abort %0d", c), N*DW'(done), N*DW'(0));
    end

    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
    streamAndCheck("run3", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
